// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching CPU: opcodes, instruction field positions,
// front-end FSM encoding and default widths. Exec imports the same opcode set.
package cpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PC_W_DEF   = 8;
    localparam int RF_AW_DEF  = 3;
    localparam int INSTR_W    = 16;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_LDL = 4'd3;
    localparam logic [3:0] OP_LDH = 4'd4;

    // rb and imm overlap; the opcode decides which one exec consumes
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 9;
    localparam int RB_MSB  = 8;
    localparam int RB_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    function automatic logic op_is_defined(input logic [3:0] op);
        return (op <= OP_LDH);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: async-reset storage, two combinational operand reads,
// one debug read and a single synchronous write port.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int RF_AW  = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [RF_AW-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RF_AW-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [RF_AW-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [RF_AW-1:0]  dbg_sel_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int NREG = 1 << RF_AW;

    logic [DATA_W-1:0] mem_q [NREG];

    // Storage array with write port
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_sel_i];

endmodule

// File: rtl/fetch_decode_wb.sv
// Fetch/decode/writeback front end: one instruction every four cycles,
// single-cycle exec strobe, sticky halt on an undefined opcode.
module fetch_decode_wb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int RF_AW  = RF_AW_DEF
) (
    input  logic              clk_ft,
    input  logic              reset,
    input  logic [PC_W-1:0]   p_count,
    input  logic [DATA_W-1:0] reg_in,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    output logic [3:0]        op_code,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [7:0]        op_data,
    output logic              ex_fire,
    output logic              halted,
    input  logic [RF_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   prog_addr_q, prog_addr_d;
    logic [RF_AW-1:0]  wb_ra_q, wb_ra_d;
    logic [3:0]        op_code_q, op_code_d;
    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [DATA_W-1:0] reg_b_q, reg_b_d;
    logic [7:0]        op_data_q, op_data_d;
    logic              ex_fire_q, ex_fire_d;
    logic              halted_q, halted_d;
    logic              rf_we_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s;

    reg_file #(.DATA_W(DATA_W), .RF_AW(RF_AW)) u_rf (
        .clk_i      (clk_ft),
        .rst_n_i    (reset),
        .we_i       (rf_we_s),
        .waddr_i    (wb_ra_q),
        .wdata_i    (reg_in),
        .raddr_a_i  (prog_data[RA_MSB:RA_LSB]),
        .rdata_a_o  (rf_a_s),
        .raddr_b_i  (prog_data[RB_MSB:RB_LSB]),
        .rdata_b_o  (rf_b_s),
        .dbg_sel_i  (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    // State and output registers
    always_ff @(posedge clk_ft or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            prog_addr_q <= '0;
            wb_ra_q     <= '0;
            op_code_q   <= 4'd0;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            op_data_q   <= 8'd0;
            ex_fire_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            wb_ra_q     <= wb_ra_d;
            op_code_q   <= op_code_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            op_data_q   <= op_data_d;
            ex_fire_q   <= ex_fire_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state and sequencing; operands are held from decode through writeback
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        wb_ra_d     = wb_ra_q;
        op_code_d   = op_code_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        op_data_d   = op_data_q;
        ex_fire_d   = 1'b0;
        halted_d    = halted_q;
        rf_we_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                prog_addr_d = p_count;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                wb_ra_d = prog_data[RA_MSB:RA_LSB];
                if (op_is_defined(prog_data[OP_MSB:OP_LSB])) begin
                    op_code_d = prog_data[OP_MSB:OP_LSB];
                    op_data_d = prog_data[IMM_MSB:IMM_LSB];
                    reg_a_d   = rf_a_s;
                    reg_b_d   = rf_b_s;
                    ex_fire_d = 1'b1;
                    state_d   = S_EXEC;
                end else begin
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                rf_we_s = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end
        endcase
    end

    assign prog_addr = prog_addr_q;
    assign op_code   = op_code_q;
    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign op_data   = op_data_q;
    assign ex_fire   = ex_fire_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_decode_wb.sv
// Randomized and directed bench for fetch_decode_wb; the bench plays exec and
// the program ROM and tracks an instruction-level model of registers and PC.
module tb_fetch_decode_wb;

    logic        clk_ft;
    logic        reset;
    logic [7:0]  p_count;
    logic [15:0] reg_in;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  op_code;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [7:0]  op_data;
    logic        ex_fire;
    logic        halted;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    logic [15:0] rom [256];
    logic [15:0] rf_m [8];
    logic [7:0]  pc_m;
    int          n_vec;
    int          n_err;

    fetch_decode_wb dut (
        .clk_ft    (clk_ft),
        .reset     (reset),
        .p_count   (p_count),
        .reg_in    (reg_in),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .op_code   (op_code),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .op_data   (op_data),
        .ex_fire   (ex_fire),
        .halted    (halted),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    assign prog_data = rom[prog_addr];

    initial clk_ft = 1'b0;
    always #10 clk_ft = ~clk_ft;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check_eq($sformatf("%s_r%0d", tag, i), dbg_data, rf_m[i]);
        end
    endtask

    task automatic apply_reset(input logic [7:0] start_pc);
        reset   = 1'b0;
        p_count = start_pc;
        reg_in  = 16'h0000;
        pc_m    = start_pc;
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
        #1;
        check_eq("rst_async_fire", ex_fire, 1'b0);
        repeat (2) @(negedge clk_ft);
        check_eq("rst_prog_addr", prog_addr, 8'h00);
        check_eq("rst_op_code", op_code, 4'h0);
        check_eq("rst_reg_a", reg_a, 16'h0000);
        check_eq("rst_reg_b", reg_b, 16'h0000);
        check_eq("rst_op_data", op_data, 8'h00);
        check_eq("rst_ex_fire", ex_fire, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_rf("rst_rf");
        reset = 1'b1;
    endtask

    // One instruction, starting at a negedge inside the fetch cycle
    task automatic run_instr(output bit stop);
        logic [15:0] instr, a, b, res;
        logic [3:0]  op;
        logic [2:0]  ra, rb;
        logic [7:0]  imm;
        stop  = 1'b0;
        instr = rom[pc_m];
        op    = instr[15:12];
        ra    = instr[11:9];
        rb    = instr[8:6];
        imm   = instr[7:0];
        a     = rf_m[ra];
        b     = rf_m[rb];
        @(negedge clk_ft);
        check_eq("prog_addr", prog_addr, pc_m);
        check_eq("fire_in_decode", ex_fire, 1'b0);
        @(negedge clk_ft);
        if (op > 4'd4) begin
            check_eq("halted_on_undef", halted, 1'b1);
            check_eq("fire_on_undef", ex_fire, 1'b0);
            stop = 1'b1;
            return;
        end
        case (op)
            4'd0:    res = b;
            4'd1:    res = a + b;
            4'd2:    res = a - b;
            4'd3:    res = {a[15:8], imm};
            4'd4:    res = {imm, a[7:0]};
            default: res = 16'h0000;
        endcase
        check_eq("fire_in_exec", ex_fire, 1'b1);
        check_eq("halted_running", halted, 1'b0);
        check_eq("op_code", op_code, op);
        check_eq("op_data", op_data, imm);
        check_eq("reg_a", reg_a, a);
        check_eq("reg_b", reg_b, b);
        reg_in  = res;
        p_count = pc_m + 8'd1;
        @(negedge clk_ft);
        check_eq("fire_in_wb", ex_fire, 1'b0);
        check_eq("hold_op_code", op_code, op);
        check_eq("hold_reg_a", reg_a, a);
        check_eq("hold_reg_b", reg_b, b);
        check_eq("hold_op_data", op_data, imm);
        @(negedge clk_ft);
        check_eq("fire_in_fetch", ex_fire, 1'b0);
        rf_m[ra] = res;
        pc_m     = pc_m + 8'd1;
        dbg_sel  = ra;
        #1;
        check_eq($sformatf("wb_r%0d", ra), dbg_data, res);
    endtask

    task automatic run_program(input int max_instr);
        bit stop;
        stop = 1'b0;
        for (int i = 0; i < max_instr && !stop; i++) begin
            run_instr(stop);
        end
        check_eq("halt_reached", stop, 1'b1);
        repeat (6) begin
            @(negedge clk_ft);
            check_eq("halt_sticky", halted, 1'b1);
            check_eq("halt_no_fire", ex_fire, 1'b0);
            check_eq("halt_prog_addr", prog_addr, pc_m);
        end
        check_rf("halt_frozen");
    endtask

    task automatic load_directed();
        for (int i = 0; i < 256; i++) rom[i] = 16'h5000;
        rom[0] = 16'h3234;  // LDL r1,0x34
        rom[1] = 16'h4212;  // LDH r1,0x12
        rom[2] = 16'h3401;  // LDL r2,0x01
        rom[3] = 16'h1440;  // ADD r2,r1
        rom[4] = 16'h2680;  // SUB r3,r2
        rom[5] = 16'h385A;  // LDL r4,0x5A
        rom[6] = 16'h0900;  // MOV r4,r4
        rom[7] = 16'h5000;
    endtask

    initial begin
        bit stop;
        logic [7:0] start;
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        p_count = 8'h00;
        reg_in  = 16'h0000;
        dbg_sel = 3'd0;

        // Undefined opcode at address 2
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h3234;
        rom[1] = 16'h4212;
        rom[2] = 16'h5000;
        apply_reset(8'h00);
        run_program(8);
        check_eq("r1_after_ldl_ldh", rf_m[1], 16'h1234);

        load_directed();
        apply_reset(8'h00);
        run_program(16);

        // Abort ADD r2,r1 while exec is strobed
        apply_reset(8'h00);
        for (int i = 0; i < 3; i++) run_instr(stop);
        @(negedge clk_ft);
        @(negedge clk_ft);
        check_eq("fire_before_abort", ex_fire, 1'b1);
        reg_in = 16'hBEEF;
        apply_reset(8'h00);
        run_program(16);

        // Random programs ending in an undefined opcode; one start forces PC wrap
        for (int p = 0; p < 4; p++) begin
            start = (p == 0) ? 8'd250 : 8'($urandom);
            for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
            for (int i = 0; i < 30; i++) begin
                rom[8'(start + 8'(i))] = {4'($urandom_range(0, 4)), 12'($urandom)};
            end
            rom[8'(start + 8'd30)] = {4'($urandom_range(5, 15)), 12'($urandom)};
            apply_reset(start);
            run_program(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode_wb.md
Name: fetch_decode_wb

Overview:
- Front end and writeback partner of the exec stage in the teaching CPU.
- Fetches the 16-bit instruction at the current program counter from program ROM and decodes it.
- Reads the 8-entry register file and presents op_code/reg_a/reg_b/op_data to exec.
- Strobes exec once per instruction, then writes exec's result back into the register file.

Parameters:
DATA_W, 16, register/result width
PC_W, 8, program counter and ROM address width
RF_AW, 3, register-file address width (2**RF_AW registers)

Ports:
clk_ft  input  1  stage clock (single clock domain)
reset  input  1  asynchronous, active-low reset
p_count  input  PC_W  program counter from exec
reg_in  input  DATA_W  result from exec
prog_addr  output  PC_W  ROM address
prog_data  input  16  ROM data, valid one cycle after prog_addr
op_code  output  4  decoded opcode to exec
reg_a  output  DATA_W  register-file value at field ra
reg_b  output  DATA_W  register-file value at field rb
op_data  output  8  immediate to exec
ex_fire  output  1  one-cycle exec enable; exec clock is qualified by this
halted  output  1  sticky halt flag
dbg_sel  input  RF_AW  register-file debug read select
dbg_data  output  DATA_W  combinational read of regfile[dbg_sel]

Behaviour:
- Reset is asynchronous and active-low, on one clock (clk_ft). When reset=0:
  - state=S_FETCH
  - all registers=0
  - prog_addr=0, op_code=0, reg_a=0, reg_b=0, op_data=0
  - ex_fire=0, halted=0
  - Asserting reset mid-instruction aborts the instruction; no writeback occurs.
- Instruction format:
  - [15:12] op
  - [11:9] ra (source A and destination)
  - [8:6] rb (MOV/ADD/SUB only)
  - [7:0] imm (LDL/LDH only)
  - The rb and imm fields overlap; the opcode selects which is used.
- Opcodes: MOV=0, ADD=1, SUB=2, LDL=3, LDH=4. Opcodes 5..15 are undefined.
- FSM: S_FETCH -> S_DECODE -> S_EXEC -> S_WB -> S_FETCH, i.e. 4 cycles per instruction.
  - S_FETCH: prog_addr<=p_count.
  - S_DECODE: latch prog_data into the instruction register.
    - Defined op: drive op_code, op_data=imm, reg_a=rf[ra], reg_b=rf[rb].
    - Undefined op: go to S_HALT with ex_fire=0.
  - S_EXEC: ex_fire=1 for exactly this cycle. Exec updates reg_in and p_count on this edge.
  - S_WB: rf[ra]<=reg_in. All five defined ops write back. ex_fire=0.
  - S_HALT: halted=1. Held until reset. No ROM reads, no writes.
- Operand hold: op_code/reg_a/reg_b/op_data stay stable from S_DECODE through S_WB.
- Self-reference: ra==rb reads the same register for both operands, using the pre-write value.
- Writes to r0 are allowed; r0 is a normal register.
- PC wrap (255 -> 0) is exec's concern; this block simply fetches the p_count it is given.
- ex_fire is never asserted in two consecutive cycles.
- Width rules:
  - reg_in is stored as-is (DATA_W bits, no extension).
  - Arithmetic overflow is handled by exec; no flags are kept here.
- dbg_data is a purely combinational read and has no effect on state.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (MOV/ADD/SUB/LDL/LDH)
  - instruction field bit positions
  - FSM state encoding (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT)
  - DATA_W/PC_W defaults
  - exec imports the same opcode constants.
- One sub-module, reg_file:
  - 2**RF_AW x DATA_W, async reset
  - two combinational read ports plus a debug read port
  - one synchronous write port

Test Plan:
- Reset with ROM[0]=LDL r1,0x34 -> after reset: state S_FETCH, all outputs 0, dbg_data=0 for all eight registers.
- LDL r1,0x34 then LDH r1,0x12 -> exactly one ex_fire every 4 cycles; r1=0x1234 after 8 cycles; prog_addr sequence 0,1.
- Prior program leaves r1=0x1234, r2=0x0001:
  - ADD r2,r1 -> reg_a=0x0001, reg_b=0x1234; r2=0x1235.
  - Then SUB r3,r2 with r3=0 -> r3=0xEDCB (wraps).
- MOV r4,r4 (ra==rb) -> reg_a==reg_b==the old r4; r4 unchanged; p_count advances by 1.
- ROM[2]=0x5000 (undefined op) -> halted=1 two cycles after fetch, ex_fire never asserted, registers frozen, prog_addr stays 2.
- Drop reset low during S_EXEC of ADD r2,r1 -> r2 stays 0, state S_FETCH on release, halted=0.
